counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
Sequencing controller for a WIDTH-bit up-counter datapath.
- Accepts a terminal-count configuration over a valid/ready handshake.
- Runs the counter on start; stops on request.
- Either auto-reloads at the limit, or reports one-shot completion over a valid/ready done handshake.
- Sits between software-facing control logic and the counting datapath; owns all counter sequencing.

Parameters:
WIDTH, 4, counter and limit width in bits (>=1)
DEFAULT_LIMIT, 2**WIDTH-1, limit value loaded at reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted this cycle if cfg_valid; high only in IDLE
cfg_limit  input  WIDTH  terminal count value
cfg_reload  input  1  1 = auto-reload mode, 0 = one-shot mode
start  input  1  begin counting (honoured in IDLE only)
stop  input  1  abort counting (honoured in RUN only)
count  output  WIDTH  current counter value
busy  output  1  high in RUN
tc  output  1  single-cycle pulse when count==limit in RUN
done_valid  output  1  one-shot completion pending
done_ready  input  1  completion consumed

Behaviour:
- Reset (async assert, sync-safe deassert on clk): state=IDLE, count=0, limit=DEFAULT_LIMIT, reload=0, tc=0, done_valid=0, busy=0. cfg_ready=1 once reset deasserts.
- Registered outputs: count, tc, done_valid. busy and cfg_ready decode state combinationally.
- IDLE:
  - cfg_valid && cfg_ready: latch cfg_limit and cfg_reload next edge.
  - start: next state RUN, count<=0.
  - cfg handshake and start in the same cycle: both take effect. The new limit applies to this run.
- RUN: each cycle compares count with limit.
  - count!=limit: count<=count+1 (mod 2^WIDTH), via incrementer sub-module.
  - count==limit, reload=1: count<=0, tc pulses next cycle, remain RUN.
  - count==limit, reload=0: tc pulses next cycle, count holds limit, next state DONE, done_valid<=1.
  - stop: next state IDLE, count<=0, no tc, no done. stop has priority over a terminal count in the same cycle.
  - start and cfg_valid are ignored; cfg_ready=0.
- DONE:
  - done_valid held high until a cycle with done_ready=1, then done_valid<=0, state IDLE, count<=0.
  - start, stop and cfg are ignored.
- Latency: start at edge N gives count=0 after N, then count=k after edge N+k. One-shot with limit L gives done_valid high after edge N+L+1.
- limit=0: reload mode pulses tc every cycle with count stuck at 0. One-shot mode gives a single RUN cycle, then DONE.
- limit=2**WIDTH-1: full range, no intermediate wrap.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; a pending done is discarded.

Optional Feature:
Macro COUNTER_CTRL_WRAP_CNT_EN.
- Defined:
  - Adds output port wraps[7:0], a count of auto-reload events.
  - Cleared to 0 on reset and on an accepted start.
  - Increments on every reload, saturating at 255.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package counter_ctrl_pkg:
  - state enum state_e {IDLE, RUN, DONE}, 2-bit encoding.
  - localparam WRAPS_W=8, WRAPS_MAX=255.
- One sub-module, counter_ctrl_inc:
  - Parameter WIDTH; combinational out=in+1 mod 2^WIDTH.
  - Instantiated once for the count datapath.
  - Not reused for the wrap counter, which saturates.

Test Plan:
1. Reset then idle: rst_n low mid-cycle -> count=0, busy=0, cfg_ready=1, done_valid=0 asynchronously. limit reads back 15 via a one-shot run with default config.
2. One-shot:
   - Stimulus: cfg_limit=5, reload=0, start.
   - count 0,1,2,3,4,5 on consecutive cycles; tc one cycle after count=5; done_valid high and held with done_ready=0 for 3 cycles.
   - done_ready=1 -> IDLE, count=0.
3. Auto-reload:
   - Stimulus: cfg_limit=2, reload=1, start, run 10 cycles.
   - count sequence 0,1,2,0,1,2,...; tc every 3rd cycle; done_valid never asserts.
   - With COUNTER_CTRL_WRAP_CNT_EN, wraps=3.
4. Stop collision: limit=3, one-shot, stop asserted the cycle count==3 -> state IDLE, count=0, no tc, no done_valid.
5. Protocol guards:
   - cfg_valid in RUN -> cfg_ready=0 and limit unchanged; start in RUN/DONE ignored.
   - limit=0 one-shot -> done_valid after 2 edges.
6. Saturation: with COUNTER_CTRL_WRAP_CNT_EN and limit=0 reload for 300 cycles -> wraps=255. A fresh start clears wraps to 0.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl sequencing controller.
// The optional reload-event counter is enabled with COUNTER_CTRL_WRAP_CNT_EN.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned WRAPS_W   = 8;
  localparam int unsigned WRAPS_MAX = 255;

  // Saturating increment for the reload-event counter; it sticks at WRAPS_MAX.
  function automatic logic [WRAPS_W-1:0] wraps_sat_inc(input logic [WRAPS_W-1:0] value);
    return (value == WRAPS_W'(WRAPS_MAX)) ? value : value + WRAPS_W'(1);
  endfunction

endpackage

// File: rtl/counter_ctrl_inc.sv
// Combinational modulo-2^WIDTH incrementer for the count datapath.
module counter_ctrl_inc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_value
);

  // Carry out of the MSB is dropped, giving natural wrap at 2^WIDTH.
  assign o_value = i_value + WIDTH'(1);

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for a WIDTH-bit up-counter: config handshake, run/stop,
// auto-reload or one-shot completion. Define COUNTER_CTRL_WRAP_CNT_EN to add the wraps port.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH         = 4,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = {WIDTH{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic               cfg_reload,
  input  logic               start,
  input  logic               stop,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               tc,
  output logic               done_valid,
  input  logic               done_ready
`ifdef COUNTER_CTRL_WRAP_CNT_EN
  ,
  output logic [WRAPS_W-1:0] wraps
`endif
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_count_inc;
  logic [WIDTH-1:0] r_limit;
  logic             r_reload;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             r_done_valid;
  logic             w_done_nxt;
  logic             w_cfg_take;
  logic             w_at_limit;

  counter_ctrl_inc #(
    .WIDTH (WIDTH)
  ) u_inc (
    .i_value (r_count),
    .o_value (w_count_inc)
  );

  assign cfg_ready  = (r_state == IDLE);
  assign busy       = (r_state == RUN);
  assign count      = r_count;
  assign tc         = r_tc;
  assign done_valid = r_done_valid;

  assign w_cfg_take = cfg_valid && cfg_ready;
  assign w_at_limit = (r_count == r_limit);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done_valid;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_count_nxt = '0;
        end
      end
      RUN: begin
        // stop wins over a terminal count landing in the same cycle.
        if (stop) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (w_at_limit) begin
          w_tc_nxt = 1'b1;
          if (r_reload) begin
            w_count_nxt = '0;
          end else begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = w_count_inc;
        end
      end
      DONE: begin
        if (done_ready) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_tc         <= 1'b0;
      r_done_valid <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_tc         <= w_tc_nxt;
      r_done_valid <= w_done_nxt;
    end
  end

  // Configuration is only writable in IDLE, so a run always sees a stable limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_limit  <= DEFAULT_LIMIT;
      r_reload <= 1'b0;
    end else if (w_cfg_take) begin
      r_limit  <= cfg_limit;
      r_reload <= cfg_reload;
    end
  end

`ifdef COUNTER_CTRL_WRAP_CNT_EN
  logic               w_start_take;
  logic               w_reload_evt;
  logic [WRAPS_W-1:0] r_wraps;

  assign w_start_take = start && (r_state == IDLE);
  assign w_reload_evt = (r_state == RUN) && !stop && w_at_limit && r_reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wraps <= '0;
    end else if (w_start_take) begin
      r_wraps <= '0;
    end else if (w_reload_evt) begin
      r_wraps <= wraps_sat_inc(r_wraps);
    end
  end

  assign wraps = r_wraps;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: directed scenarios plus random stimulus against
// a behavioural model. Compile with COUNTER_CTRL_WRAP_CNT_EN to also cover wraps.
`timescale 1ns/1ps
module tb_counter_ctrl;

  localparam int WIDTH = 4;
  localparam int MODN  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_reload;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done_valid;
  logic             done_ready;
`ifdef COUNTER_CTRL_WRAP_CNT_EN
  logic [7:0]       wraps;
`endif

  counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_limit  (cfg_limit),
    .cfg_reload (cfg_reload),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .done_valid (done_valid),
    .done_ready (done_ready)
`ifdef COUNTER_CTRL_WRAP_CNT_EN
    ,
    .wraps      (wraps)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit tc;
    bit dv;
    bit busy;
    bit rdy;
    int wraps;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: "running"/"finished" flags plus plain integer arithmetic.
  bit m_run, m_fin, m_reload, m_tc;
  int m_count, m_limit, m_wraps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run    = 0;
    m_fin    = 0;
    m_reload = 0;
    m_tc     = 0;
    m_count  = 0;
    m_limit  = MODN - 1;
    m_wraps  = 0;
    exp_q.delete();
    done_q.delete();
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    exp_t e;
    m_tc = 0;
    if (!m_run && !m_fin) begin
      if (cfg_valid) begin
        m_limit  = int'(cfg_limit);
        m_reload = cfg_reload;
      end
      if (start) begin
        m_run   = 1;
        m_count = 0;
        m_wraps = 0;
      end
    end else if (m_run) begin
      if (stop) begin
        m_run   = 0;
        m_count = 0;
      end else if (m_count == m_limit) begin
        m_tc = 1;
        if (m_reload) begin
          m_count = 0;
          if (m_wraps < 255) m_wraps++;
        end else begin
          m_run = 0;
          m_fin = 1;
          done_q.push_back(m_limit);
        end
      end else begin
        m_count = (m_count + 1) % MODN;
      end
    end else if (done_ready) begin
      m_fin   = 0;
      m_count = 0;
    end
    e.count = m_count;
    e.tc    = m_tc;
    e.dv    = m_fin;
    e.busy  = m_run;
    e.rdy   = !m_run && !m_fin;
    e.wraps = m_wraps;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit cv, input int lim, input bit rl, input bit st,
                       input bit sp, input bit dr);
    @(negedge clk);
    #1;
    cfg_valid  = cv;
    cfg_limit  = lim[WIDTH-1:0];
    cfg_reload = rl;
    start      = st;
    stop       = sp;
    done_ready = dr;
    model_step();
  endtask

  task automatic idle_inputs();
    cfg_valid  = 0;
    cfg_limit  = '0;
    cfg_reload = 0;
    start      = 0;
    stop       = 0;
    done_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 0;
    idle_inputs();
    model_reset();
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_done_valid", 32'(done_valid), 0);
    check("rst_tc", 32'(tc), 0);
`ifdef COUNTER_CTRL_WRAP_CNT_EN
    check("rst_wraps", 32'(wraps), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Per-cycle monitor: one expected snapshot per clock edge the driver issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", 32'(count), e.count);
        check("tc", 32'(tc), 32'(e.tc));
        check("done_valid", 32'(done_valid), 32'(e.dv));
        check("busy", 32'(busy), 32'(e.busy));
        check("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
`ifdef COUNTER_CTRL_WRAP_CNT_EN
        check("wraps", 32'(wraps), e.wraps);
`endif
      end
    end
  end

  // Completion monitor: samples just before the edge that consumes a done.
  initial begin
    int lim;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1 && done_valid === 1'b1 && done_ready === 1'b1) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(done_valid), 0);
        end else begin
          lim = done_q.pop_front();
          check("done_count", 32'(count), lim);
        end
      end
    end
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    #12;
    check("por_count", 32'(count), 0);
    check("por_cfg_ready", 32'(cfg_ready), 1);
    check("por_busy", 32'(busy), 0);
    check("por_done_valid", 32'(done_valid), 0);
    @(negedge clk);
    rst_n = 1;

    // Default limit (15) one-shot run.
    cycle(0, 0, 0, 1, 0, 0);
    repeat (18) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // One-shot limit 5, done held for 3 cycles.
    cycle(1, 5, 0, 1, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);

    // Auto-reload limit 2 over 10 cycles, then stop.
    cycle(1, 2, 1, 1, 0, 0);
    repeat (9) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);

    // Stop colliding with terminal count.
    cycle(1, 3, 0, 1, 0, 0);
    for (int i = 0; i < 8 && !(m_run && m_count == 3); i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Protocol guards: cfg and start ignored in RUN; cfg/start/stop ignored in DONE.
    cycle(1, 6, 0, 1, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 2, 1, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Limit 0 one-shot.
    cycle(1, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Limit 0 reload for 300 cycles (wraps saturates), fresh start clears it.
    cycle(1, 0, 1, 1, 0, 0);
    repeat (300) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);

    // Reset mid-RUN and in DONE; default limit returns afterwards.
    cycle(1, 9, 0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(1, 1, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 1, 0, 0);
    repeat (17) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 2) == 0), int'($urandom_range(0, MODN - 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    // Drain back to IDLE.
    repeat (3) cycle(0, 0, 0, 0, 1, 1);
    @(posedge clk);
    #3;
    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("done_q_drained", 32'(done_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
